// File: rtl/serial_add_seq_if.sv
// -----------------------------------------------------------------------------
// serial_add_seq_if
// Handshake and data bundle for the bit-serial adder.
//   master modport : the producer/consumer side (testbench or system logic)
//   slave modport  : the adder side
// Signals
//   ena        global enable; low freezes the adder
//   in_valid   operand beat offered           in_ready  adder can accept a beat
//   a, b, cin  operands and carry-in
//   out_valid  result held and valid          out_ready consumer takes the result
//   sum, cout  result A+B+cin and carry out of the MSB
//   ovf        signed overflow
//   busy       adder is stepping through bits
// -----------------------------------------------------------------------------
interface serial_add_seq_if #(
  parameter int WIDTH = 8
) ();

  logic             ena;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output ena,
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
    input  out_valid,
    output out_ready,
    input  sum,
    input  cout,
    input  ovf,
    input  busy
  );

  modport slave (
    input  ena,
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
    output out_valid,
    input  out_ready,
    output sum,
    output cout,
    output ovf,
    output busy
  );

endinterface

// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
// Bit-serial ripple adder. An operand beat (a, b, cin) is accepted in IDLE,
// one bit per enabled clock is added LSB first in RUN, and the result is held
// in DONE until the consumer takes it.
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (priority over ena and handshakes)
//   bus   serial_add_seq_if.slave (ena, operand handshake, result handshake)
// -----------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_seq_if.slave  bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of a single-bit full add.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_handshake;
  logic              w_last;
  logic [1:0]        w_fa;

  assign w_in_ready  = (r_state == ST_IDLE) && bus.ena;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_handshake = (r_state == ST_DONE) && bus.out_ready && bus.ena;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_fa        = full_add(r_a[r_idx], r_b[r_idx], r_carry);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; every move needs ena, otherwise the FSM holds.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (w_handshake) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Datapath: operand latch, bit stepping and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.ena) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // The carry register is seeded with cin so bit 0 needs no special case.
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sum[r_idx] <= w_fa[0];
          r_carry      <= w_fa[1];
          if (w_last) begin
            // r_carry still holds the carry into the MSB at this point.
            r_cout <= w_fa[1];
            r_ovf  <= r_carry ^ w_fa[1];
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          r_idx <= r_idx;
        end
        default: begin
          r_idx <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.out_valid = (r_state == ST_DONE);

  serial_add_seq_chk #(.WIDTH(WIDTH)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .ena       (bus.ena),
    .in_ready  (w_in_ready),
    .out_valid (r_state == ST_DONE),
    .out_ready (bus.out_ready),
    .busy      (r_state == ST_RUN),
    .sum       (r_sum),
    .cout      (r_cout),
    .ovf       (r_ovf)
  );

endmodule

// -----------------------------------------------------------------------------
// serial_add_seq_chk
// Protocol invariants of the serial adder: the three state decodes are
// mutually exclusive and a held result does not change until it is taken.
// -----------------------------------------------------------------------------
module serial_add_seq_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             ena,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic             busy,
  input logic [WIDTH-1:0] sum,
  input logic             cout,
  input logic             ovf
);

  a_excl_run_done: assert property (@(posedge clk) disable iff (rst)
    !(out_valid && busy));

  a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
    in_ready |-> (!busy && !out_valid));

  a_result_held: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !(out_ready && ena)) |=>
      (out_valid && $stable(sum) && $stable(cout) && $stable(ovf)));

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_add_seq_if #(.WIDTH(W)) bus ();

  serial_add_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_sum;
  int exp_cout;
  int exp_ovf;
  int last_cycles;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic report_timeout(input string tag);
    n_compared++;
    n_mismatched++;
    $display("FAIL %s: wait bound expired", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: plain integer arithmetic, signed overflow by range test.
  function automatic void ref_add(input int a, input int b, input int cin,
                                  output int s, output int co, output int ov);
    int u;
    int sa;
    int sb;
    int ts;
    u  = a + b + cin;
    s  = u % (1 << W);
    co = u / (1 << W);
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    ts = sa + sb + cin;
    ov = (ts > (1 << (W - 1)) - 1 || ts < -(1 << (W - 1))) ? 1 : 0;
  endfunction

  // Accept one operand beat and step until the model says the result is ready.
  // mode 0: ena held high; 1: random ena gaps; 2: ena low for 3 cycles at idx 4.
  task automatic run_op(input int a, input int b, input int cin, input int mode);
    int  hi;
    int  lows;
    int  cyc;
    bit  e;
    ref_add(a, b, cin, exp_sum, exp_cout, exp_ovf);
    bus.ena       = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = W'(a);
    bus.b         = W'(b);
    bus.cin       = 1'(cin);
    bus.out_ready = 1'b0;
    #1;
    check_value("in_ready_idle", 32'(bus.in_ready), 32'd1);
    step();
    check_value("busy_after_accept", 32'(bus.busy), 32'd1);
    hi   = 0;
    lows = 0;
    cyc  = 0;
    while (hi < W && cyc < 200) begin
      case (mode)
        0:       e = 1'b1;
        1:       e = ($urandom_range(0, 3) != 0);
        2:       e = !(hi == 4 && lows < 3);
        default: e = 1'b1;
      endcase
      bus.ena       = e;
      bus.in_valid  = 1'($urandom);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.cin       = 1'($urandom);
      bus.out_ready = 1'($urandom);
      #1;
      check_value("in_ready_run", 32'(bus.in_ready), 32'd0);
      step();
      cyc++;
      if (e) hi++;
      else lows++;
      check_value("out_valid_latency", 32'(bus.out_valid), 32'(hi >= W));
      check_value("busy_latency", 32'(bus.busy), 32'(hi < W));
    end
    if (hi < W) report_timeout("run_done_wait");
    last_cycles = cyc;
    check_value("sum", 32'(bus.sum), 32'(exp_sum));
    check_value("cout", 32'(bus.cout), 32'(exp_cout));
    check_value("ovf", 32'(bus.ovf), 32'(exp_ovf));
  endtask

  // Hold the result under backpressure for 'gap' cycles, then take it.
  task automatic finish_op(input int gap, input bit rand_ena);
    int cnt;
    bit done;
    bit r;
    bit e;
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 200) begin
      r = (cnt >= gap);
      e = rand_ena ? 1'($urandom) : 1'b1;
      bus.out_ready = r;
      bus.ena       = e;
      bus.in_valid  = 1'b1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      #1;
      check_value("in_ready_done", 32'(bus.in_ready), 32'd0);
      check_value("out_valid_held", 32'(bus.out_valid), 32'd1);
      check_value("sum_held", 32'(bus.sum), 32'(exp_sum));
      check_value("cout_held", 32'(bus.cout), 32'(exp_cout));
      check_value("ovf_held", 32'(bus.ovf), 32'(exp_ovf));
      step();
      cnt++;
      if (r && e) done = 1'b1;
    end
    if (!done) report_timeout("result_handshake_wait");
    check_value("out_valid_cleared", 32'(bus.out_valid), 32'd0);
    check_value("busy_after_take", 32'(bus.busy), 32'd0);
    bus.ena       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_value("in_ready_after_take", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_value({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_value({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_value({tag, "_sum"}, 32'(bus.sum), 32'd0);
    check_value({tag, "_cout"}, 32'(bus.cout), 32'd0);
    check_value({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    bus.ena = 1'b1;
    #1;
    check_value({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.ena       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_reset_state("por");

    // Carry ripples through every bit.
    run_op(8'hFF, 8'h01, 0, 0);
    check_value("lat_nominal", 32'(last_cycles), 32'd8);
    check_value("ff01_sum", 32'(bus.sum), 32'h00);
    check_value("ff01_cout", 32'(bus.cout), 32'd1);
    check_value("ff01_ovf", 32'(bus.ovf), 32'd0);
    finish_op(0, 1'b0);

    run_op(8'h7F, 8'h01, 0, 0);
    check_value("7f01_sum", 32'(bus.sum), 32'h80);
    check_value("7f01_cout", 32'(bus.cout), 32'd0);
    check_value("7f01_ovf", 32'(bus.ovf), 32'd1);
    finish_op(0, 1'b0);

    run_op(8'h80, 8'h80, 1, 0);
    check_value("8080_sum", 32'(bus.sum), 32'h01);
    check_value("8080_cout", 32'(bus.cout), 32'd1);
    check_value("8080_ovf", 32'(bus.ovf), 32'd1);
    finish_op(0, 1'b0);

    // Enable gap mid-operation, then 5 cycles of backpressure.
    run_op(8'h5A, 8'h33, 0, 2);
    check_value("lat_stretched", 32'(last_cycles), 32'd11);
    check_value("5a33_sum", 32'(bus.sum), 32'h8D);
    check_value("5a33_cout", 32'(bus.cout), 32'd0);
    check_value("5a33_ovf", 32'(bus.ovf), 32'd1);
    finish_op(5, 1'b0);

    // Reset at idx 3 with a live carry, then a clean add.
    bus.ena      = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.cin      = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_value("busy_before_rst", 32'(bus.busy), 32'd1);
    rst     = 1'b1;
    bus.ena = 1'b0;
    step();
    rst = 1'b0;
    check_reset_state("rst_run");
    run_op(8'h12, 8'h34, 0, 0);
    check_value("1234_sum", 32'(bus.sum), 32'h46);
    check_value("1234_cout", 32'(bus.cout), 32'd0);
    finish_op(1, 1'b0);

    // Reset while a result is held.
    run_op(8'hC3, 8'h5D, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_done");

    // Random regression.
    for (int n = 0; n < 1000; n++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), 1);
      finish_op(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
